// File: rtl/ssd_score_scanner.sv
// Seven-segment score display: sequential double-dabble binary-to-BCD plus anode scanning.
// Optional leading-zero blanking is enabled by defining SSD_LZB_EN.
module ssd_score_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 8,
  parameter int SCAN_DIV_W = 18
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [VALUE_W-1:0]    Value,
  input  logic                  Load,
  input  logic [NUM_DIGITS-1:0] Dp_Mask,
  output logic                  Busy,
  output logic                  Overflow,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Seg
);
  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int ITER_W = $clog2(VALUE_W + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  ovf_q;
  logic                  sticky_q;
  logic                  pend_vld_q;
  logic [VALUE_W-1:0]    pend_val_q;
  logic [VALUE_W-1:0]    bin_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [BCD_W-1:0]      disp_q;
  logic [ITER_W-1:0]     iter_q;
  logic [SCAN_DIV_W-1:0] pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [7:0]            seg_q;

  logic [BCD_W-1:0]      bcd_adj_d;
  logic [BCD_W-1:0]      bcd_d;
  logic [VALUE_W-1:0]    bin_d;
  logic                  carry_d;
  logic [3:0]            digit_d;
  logic                  dp_d;
  logic                  blank_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            seg_d;
`ifdef SSD_LZB_EN
  logic                  nz_above;
`endif

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0000001;
      4'd1:    seg_encode = 7'b1001111;
      4'd2:    seg_encode = 7'b0010010;
      4'd3:    seg_encode = 7'b0000110;
      4'd4:    seg_encode = 7'b1001100;
      4'd5:    seg_encode = 7'b0100100;
      4'd6:    seg_encode = 7'b0100000;
      4'd7:    seg_encode = 7'b0001111;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0000100;
      default: seg_encode = 7'b1111111;
    endcase
  endfunction

  // One double-dabble iteration; the bit leaving the top nibble flags overflow.
  always_comb begin
    bcd_adj_d = dabble_adjust(bcd_q);
    {carry_d, bcd_d, bin_d} = {bcd_adj_d, bin_q, 1'b0};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (Load && (state_q != IDLE)) begin
        pend_val_q <= Value;
        pend_vld_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (Load) begin
            bin_q    <= Value;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            iter_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= CONV;
          end
        end
        CONV: begin
          bin_q    <= bin_d;
          bcd_q    <= bcd_d;
          sticky_q <= sticky_q | carry_d;
          iter_q   <= iter_q + 1'b1;
          if (iter_q == ITER_LAST) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q <= bcd_q;
          ovf_q  <= sticky_q;
          // A Load arriving in this very cycle is newer than any queued one.
          if (Load || pend_vld_q) begin
            bin_q      <= Load ? Value : pend_val_q;
            bcd_q      <= '0;
            sticky_q   <= 1'b0;
            iter_q     <= '0;
            pend_vld_q <= 1'b0;
            state_q    <= CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    digit_d = 4'd0;
    dp_d    = 1'b0;
    blank_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_d = disp_q[4*i +: 4];
        dp_d    = Dp_Mask[i];
      end
    end
`ifdef SSD_LZB_EN
    // Walk down from the top digit; blank until the first nonzero digit is seen.
    nz_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (disp_q[4*i +: 4] != 4'd0) nz_above = 1'b1;
      if ((idx_q == IDX_W'(i)) && !nz_above) blank_d = 1'b1;
    end
`endif
    if (ovf_q)        seg_d = {7'b1111110, ~dp_d};
    else if (blank_d) seg_d = {7'b1111111, ~dp_d};
    else              seg_d = {seg_encode(digit_d), ~dp_d};
    an_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= 8'hFF;
    end else begin
      pre_q <= pre_q + 1'b1;
      if (&pre_q) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign Busy     = busy_q;
  assign Overflow = ovf_q;
  assign An       = an_q;
  assign Seg      = seg_q;

endmodule

// File: tb/tb_ssd_score_scanner.sv
// Randomised scoreboard bench for ssd_score_scanner: transaction model in decimal arithmetic,
// per-cycle monitor decoding the expected digit for each scan slot.
module tb_ssd_score_scanner;
  localparam int ND = 4;
  localparam int VW = 14;
  localparam int SD = 2;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          Load = 1'b0;
  logic [VW-1:0] Value = '0;
  logic [ND-1:0] Dp_Mask = '0;
  logic          Busy;
  logic          Overflow;
  logic [ND-1:0] An;
  logic [7:0]    Seg;

  ssd_score_scanner #(.NUM_DIGITS(ND), .VALUE_W(VW), .SCAN_DIV_W(SD)) dut (
    .CLK(CLK), .Reset(Reset), .Value(Value), .Load(Load), .Dp_Mask(Dp_Mask),
    .Busy(Busy), .Overflow(Overflow), .An(An), .Seg(Seg)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            rst;
    bit            busy;
    bit            commit;
    int unsigned   val;
    logic [ND-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;

  bit          busy_m = 1'b0;
  bit          pend_m = 1'b0;
  int unsigned cur_m = 0;
  int unsigned pend_val_m = 0;
  int          cedge_m = 0;

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_table(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [7:0] seg_model(input int unsigned val, input int idx,
                                           input logic [ND-1:0] mask);
    logic dp;
    int   d;
    dp = ~mask[idx];
    if (val >= pow10(ND)) return {7'b1111110, dp};
`ifdef SSD_LZB_EN
    if ((idx > 0) && (val < pow10(idx))) return {7'b1111111, dp};
`endif
    d = int'((val / pow10(idx)) % 10);
    return {seg_table(d), dp};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, then advance the transaction model for the edge that samples it.
  task automatic step(input bit rst, input bit ld, input int unsigned v, input logic [ND-1:0] m);
    exp_t e;
    Reset   = rst;
    Load    = ld;
    Value   = VW'(v);
    Dp_Mask = m;
    @(posedge CLK);
    edge_n++;
    e.rst    = rst;
    e.commit = 1'b0;
    e.val    = 0;
    e.mask   = m;
    if (rst) begin
      busy_m = 1'b0;
      pend_m = 1'b0;
    end else begin
      if (ld) begin
        if (!busy_m) begin
          busy_m  = 1'b1;
          cur_m   = v;
          cedge_m = edge_n + VW + 1;
        end else begin
          pend_m     = 1'b1;
          pend_val_m = v;
        end
      end
      if (busy_m && (edge_n == cedge_m)) begin
        e.commit = 1'b1;
        e.val    = cur_m;
        if (pend_m) begin
          cur_m   = pend_val_m;
          pend_m  = 1'b0;
          cedge_m = edge_n + VW + 1;
        end else begin
          busy_m = 1'b0;
        end
      end
    end
    e.busy = busy_m;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input logic [ND-1:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, m);
  endtask

  bit          started = 1'b0;
  int          j_m = 0;
  int unsigned disp_m = 0;

  always @(negedge CLK) begin : monitor
    exp_t          e;
    int            idx;
    logic [ND-1:0] ean;
    logic [7:0]    es;
    bit            eovf;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.rst) begin
        started = 1'b1;
        j_m     = 0;
        disp_m  = 0;
        chk("reset_an", 32'(An), 32'({ND{1'b1}}));
        chk("reset_seg", 32'(Seg), 32'(8'hFF));
        chk("reset_busy", 32'(Busy), 32'(0));
        chk("reset_ovf", 32'(Overflow), 32'(0));
      end else if (started) begin
        j_m++;
        idx = ((j_m - 1) >> SD) % ND;
        ean = ~(ND'(1) << idx);
        es  = seg_model(disp_m, idx, e.mask);
        chk("an", 32'(An), 32'(ean));
        chk("seg", 32'(Seg), 32'(es));
        if (e.commit) disp_m = e.val;
        eovf = (disp_m >= pow10(ND));
        chk("busy", 32'(Busy), 32'(e.busy));
        chk("overflow", 32'(Overflow), 32'(eovf));
      end
    end
  end

  initial begin
    int unsigned   r;
    int unsigned   v;
    logic [ND-1:0] mask;
    step(1'b1, 1'b0, 0, '0);
    step(1'b1, 1'b1, 77, '0);
    idle(20, '0);
    step(1'b0, 1'b1, 137, '0);
    idle(40, '0);
    step(1'b0, 1'b1, 255, '0);
    idle(3, '0);
    step(1'b0, 1'b1, 42, '0);
    idle(3, '0);
    step(1'b0, 1'b1, 7, '0);
    idle(50, '0);
    step(1'b0, 1'b1, 9999, 4'b0001);
    idle(40, 4'b0001);
    step(1'b0, 1'b1, 10000, 4'b1111);
    idle(40, 4'b1111);
    step(1'b0, 1'b1, 16383, '0);
    idle(30, '0);
    step(1'b0, 1'b1, 99, '0);
    idle(40, '0);
    step(1'b0, 1'b1, 5, '0);
    idle(40, '0);
    step(1'b0, 1'b1, 0, '0);
    idle(40, '0);
    step(1'b0, 1'b1, 1234, 4'b1010);
    idle(VW, 4'b1010);
    step(1'b0, 1'b1, 4321, 4'b1010);
    idle(50, 4'b1010);
    step(1'b0, 1'b1, 200, '0);
    idle(5, '0);
    step(1'b1, 1'b1, 999, '0);
    idle(30, 4'b0100);
    mask = '0;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 16383) : $urandom_range(0, 120);
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)), v, mask);
      else if (r < 20) step(1'b0, 1'b1, v, mask);
      else             step(1'b0, 1'b0, 0, mask);
      if ($urandom_range(0, 49) == 0) mask = ND'($urandom);
    end
    idle(3, '0);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd_score_scanner.md
Name: ssd_score_scanner

Overview:
Parametrised seven-segment score display engine. It converts a binary game value (snake length or score) to BCD with a sequential double-dabble converter and time-multiplexes NUM_DIGITS anodes from an internal refresh prescaler. It replaces the fixed two-digit, combinational `% 10` display path in the top level. It sits between the game core's score output and the board's An*/Ca..Cg/Dp pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits/anodes (1..8)
VALUE_W, 8, width of binary input value (1..27)
SCAN_DIV_W, 18, prescaler width; one digit step every 2^SCAN_DIV_W CLK cycles

Ports:
CLK  input  1  system clock (board_clk domain)
Reset  input  1  synchronous, active-high reset
Value  input  VALUE_W  unsigned binary value to display
Load  input  1  single-cycle strobe; capture Value and start conversion
Dp_Mask  input  NUM_DIGITS  bit i=1 lights decimal point of digit i
Busy  output  1  conversion in progress
Overflow  output  1  last converted value >= 10^NUM_DIGITS
An  output  NUM_DIGITS  anode enables, active-low, An[0] = least-significant digit
Seg  output  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low

Behaviour:
- Reset (sync, Reset=1 at posedge CLK): An all 1s, Seg=8'hFF, Busy=0, Overflow=0, display BCD register=0, pending flag=0, digit index=0, prescaler=0.
- FSM states: IDLE, CONV, COMMIT.
- IDLE: on Load=1, capture Value into shift register, clear BCD work register, iteration count=0, Busy=1, go to CONV.
- CONV: one iteration per cycle. Add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1. Any bit shifted out of the top nibble sets a sticky overflow flag. After VALUE_W iterations go to COMMIT.
- COMMIT: copy BCD work register to the display register and the overflow flag to Overflow, all in one cycle. Busy=0 next cycle. Return to IDLE.
- Latency: Load in cycle t; display register and Overflow updated at edge t+VALUE_W+2; Busy high for cycles t+1..t+VALUE_W+1.
- Load while Busy: Value captured into a pending register (last Load wins) and pending flag set. On COMMIT with pending set, the FSM goes directly to CONV with the pending value; no IDLE cycle. Busy stays high.
- Load in the same cycle as Reset: ignored. Reset mid-conversion aborts it; the display returns to 0.
- Display register changes only in COMMIT; scanning never shows partial results.
- Scan: prescaler increments every cycle and wraps at 2^SCAN_DIV_W-1. On wrap, digit index increments, wrapping from NUM_DIGITS-1 to 0.
- An and Seg are registered, recomputed every cycle from the current index. An has exactly one bit low (the bit at the index), except in the first cycle after reset.
- Segment encoding (Ca..Cg, active-low, Dp bit from ~Dp_Mask[idx]):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Overflow=1: every digit shows dash (Ca..Cg=1111110). Dp still follows Dp_Mask.

Optional Feature:
SSD_LZB_EN: when defined, leading-zero blanking is applied.
- Any digit above the most significant nonzero digit outputs Seg=8'hFF, except that Dp follows Dp_Mask. Its anode is still driven low in its slot, so brightness stays uniform.
- Digit 0 is never blanked.
- Not applied while Overflow=1.
When not defined, all digits show their value including leading zeros.

Test Plan:
1. Reset, SCAN_DIV_W=2, NUM_DIGITS=4, SSD_LZB_EN off -> An cycles 1110,1101,1011,0111 every 4 cycles; Seg=00000011 on all digits; Busy=0.
2. Load Value=8'd137 -> Busy high for 9 cycles; display 0137; digit0 Seg=00011111, digit1 Seg=00001101, digit2 Seg=10011111.
3. Load 255, then Load 42 and Load 7 during Busy -> 255 shown, then 7 committed with no IDLE gap; 42 never displayed.
4. NUM_DIGITS=2, Load 8'd100 -> Overflow=1, both digits Seg=11111101; then Load 99 -> Overflow=0, shows 99.
5. SSD_LZB_EN on, Load 5 -> digits 3..1 Seg=8'hFF, digit0 Seg=01001001; Load 0 -> digit0 shows 0.
6. Assert Reset during CONV of 200 -> Busy=0 next cycle, display 0; Dp_Mask=4'b0100 lights Dp (bit0=0) only on digit 2.
